// File: rtl/avalon_st_pipeline.sv
// Avalon-ST register pipeline: STAGES cascaded slices, each a forward register or a skid buffer.
// Optional occupancy counter output enabled by AVALON_ST_PIPELINE_OCCUPANCY_EN.
module avalon_st_pipeline #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned REG_READY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
  ,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy_o
`endif
);

  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_ready;
  logic [STAGES-1:0] dn_ready;
  logic [STAGES-1:0] main_valid;
  logic [DWIDTH-1:0] up_data   [STAGES];
  logic [DWIDTH-1:0] main_data [STAGES];
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
  logic [STAGES-1:0] skid_valid;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    // Chain wiring: each slice's upstream is the previous slice's main register.
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid_i;
      assign up_data[i]  = in_data_i;
    end else begin : g_mid
      assign up_valid[i] = main_valid[i-1];
      assign up_data[i]  = main_data[i-1];
    end
    if (i == LAST) begin : g_tail
      assign dn_ready[i] = out_ready_i;
    end else begin : g_inner
      assign dn_ready[i] = up_ready[i+1];
    end

    if (REG_READY != 0) begin : g_skid
      logic              main_v;
      logic              skid_v;
      logic [DWIDTH-1:0] main_d;
      logic [DWIDTH-1:0] skid_d;
      logic              take;
      logic              acc;

      assign take          = main_v && dn_ready[i];
      assign acc           = up_valid[i] && !skid_v;
      assign up_ready[i]   = !skid_v;
      assign main_valid[i] = main_v;
      assign main_data[i]  = main_d;
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
      assign skid_valid[i] = skid_v;
`endif

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
          main_d <= '0;
          skid_d <= '0;
        end else if (flush_i) begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end else if (take && skid_v) begin
          main_d <= skid_d;
          skid_v <= 1'b0;
        end else if (acc && (!main_v || take)) begin
          main_v <= 1'b1;
          main_d <= up_data[i];
        end else if (acc) begin
          skid_v <= 1'b1;
          skid_d <= up_data[i];
        end else if (take) begin
          main_v <= 1'b0;
        end
      end
    end else begin : g_fwd
      logic              v_q;
      logic [DWIDTH-1:0] d_q;

      assign up_ready[i]   = !v_q || dn_ready[i];
      assign main_valid[i] = v_q;
      assign main_data[i]  = d_q;
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
      assign skid_valid[i] = 1'b0;
`endif

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else if (flush_i) begin
          v_q <= 1'b0;
        end else if (up_ready[i]) begin
          v_q <= up_valid[i];
          if (up_valid[i]) d_q <= up_data[i];
        end
      end
    end
  end

  // Flush blocks both boundary handshakes for the cycle it is asserted.
  assign in_ready_o  = up_ready[0] && !flush_i;
  assign out_valid_o = main_valid[LAST] && !flush_i;
  assign out_data_o  = main_data[LAST];

`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] pop_c;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupancy_o <= '0;
    end else if (flush_i) begin
      occupancy_o <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy_o <= occupancy_o + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy_o <= occupancy_o - OCC_W'(1);
    end
  end

  // Population count of every held valid bit, for the consistency assertion.
  always_comb begin
    pop_c = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      pop_c = pop_c + OCC_W'(main_valid[k]) + OCC_W'(skid_valid[k]);
    end
  end

  occupancy_matches_valids: assert property (@(posedge clk_i) disable iff (rst_i)
    occupancy_o == pop_c);
`endif

endmodule

// File: tb/tb_avalon_st_pipeline.sv
// Scoreboard bench for avalon_st_pipeline: several STAGES/REG_READY configurations run in parallel.
`timescale 1ns/1ps
module tb_avalon_st_pipeline;

  localparam int NC = 5;

  function automatic int cfg_stages(input int k);
    case (k)
      0:       return 3;
      1:       return 2;
      2:       return 16;
      3:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_rr(input int k);
    return (k < 3) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n_done  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int inst, input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d", inst, name, act, exp);
    end
  endtask

  task automatic mark_done();
    n_done++;
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int S   = cfg_stages(g);
    localparam int R   = cfg_rr(g);
    localparam int CAP = (R != 0) ? 2 * S : S;

    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
    logic [$clog2(2*S+1)-1:0] occ;
`endif
    logic [7:0] q [$];

    avalon_st_pipeline #(.DWIDTH(8), .STAGES(S), .REG_READY(R)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_data_i   (in_data),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_data_o  (out_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
      ,
      .occupancy_o (occ)
`endif
    );

    // Monitor: the model is an ordered queue of accepted beats with a fixed capacity.
    always @(negedge clk) begin
      if (!rst) begin
        if (flush) begin
          check(g, "flush_out_valid", int'(out_valid), 0);
          check(g, "flush_in_ready", int'(in_ready), 0);
          q.delete();
        end else begin
`ifdef AVALON_ST_PIPELINE_OCCUPANCY_EN
          check(g, "occupancy", int'(occ), q.size());
`endif
          if (R == 0 || q.size() == 0 || q.size() == CAP)
            check(g, "in_ready", int'(in_ready),
                  (q.size() < CAP) ? 1 : ((R == 0) ? int'(out_ready) : 0));
          if (out_valid && out_ready) begin
            if (q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL cfg%0d stray_beat: got data %0d, expected no beat", g, out_data);
            end else begin
              check(g, "data", int'(out_data), int'(q.pop_front()));
            end
          end
          if (in_valid && in_ready) q.push_back(in_data);
        end
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    initial begin : stim
      int  acc, first_acc, first_out, last_out, nout, stalls, nfill;
      bit  took;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check(g, "rst_out_valid", int'(out_valid), 0);
      check(g, "rst_out_data", int'(out_data), 0);
      check(g, "rst_in_ready", int'(in_ready), 1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check(g, "post_rst_in_ready", int'(in_ready), 1);
      check(g, "post_rst_out_valid", int'(out_valid), 0);

      // Back-to-back stream 0x01..0x20 with the sink always ready.
      step();
      in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b1;
      acc = 0; first_acc = -1; first_out = -1; last_out = -1; nout = 0; stalls = 0;
      for (int c = 0; c < 32 + S + 8; c++) begin
        @(negedge clk);
        took = in_valid && in_ready;
        if (took) begin
          if (acc == 0) first_acc = cyc;
          acc++;
        end else if (in_valid) begin
          stalls++;
        end
        if (out_valid) begin
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          nout++;
        end
        step();
        if (took) in_data = in_data + 8'd1;
        if (acc == 32) in_valid = 1'b0;
      end
      check(g, "stream_accepted", acc, 32);
      check(g, "stream_stalls", stalls, 0);
      check(g, "stream_emitted", nout, 32);
      check(g, "stream_latency", first_out - first_acc, S);
      check(g, "stream_contiguous", last_out - first_out, 31);

      // Fill against a stalled sink, then release.
      in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0; acc = 0;
      for (int c = 0; c < CAP + 2 * S + 6; c++) begin
        @(negedge clk);
        took = in_valid && in_ready;
        if (took) acc++;
        step();
        if (took) in_data = in_data + 8'd1;
      end
      check(g, "cap_accepted", acc, CAP);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check(g, "ready_comb_dependence", int'(in_ready), (R == 0) ? 1 : 0);
      first_out = -1; last_out = -1; nout = 0;
      for (int c = 0; c < CAP + S + 6; c++) begin
        @(negedge clk);
        if (out_valid) begin
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          nout++;
        end
        step();
      end
      check(g, "drain_count", nout, CAP);
      check(g, "drain_contiguous", last_out - first_out, CAP - 1);

      // Flush with a partly filled pipe while 0xAA is offered.
      nfill = (CAP < 3) ? CAP : 3;
      in_valid = 1'b1; in_data = 8'h10; out_ready = 1'b0; acc = 0;
      for (int c = 0; c < 20 && acc < nfill; c++) begin
        @(negedge clk);
        took = in_valid && in_ready;
        if (took) acc++;
        step();
        if (took) in_data = in_data + 8'd1;
      end
      check(g, "flush_fill", acc, nfill);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
      @(negedge clk);
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check(g, "after_flush_out_valid", int'(out_valid), 0);
      check(g, "after_flush_in_ready", int'(in_ready), 1);
      step();
      in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
      @(negedge clk);
      check(g, "post_flush_accept", int'(in_ready), 1);
      first_acc = cyc;
      step();
      in_valid = 1'b0;
      first_out = -1;
      for (int c = 0; c < S + 4; c++) begin
        @(negedge clk);
        if (out_valid && first_out < 0) begin
          first_out = cyc;
          check(g, "post_flush_data", int'(out_data), 8'h55);
        end
        step();
      end
      check(g, "post_flush_latency", first_out - first_acc, S);

      // Asynchronous reset with the pipe about half full.
      nfill = (CAP + 1) / 2;
      in_valid = 1'b1; in_data = 8'h30; out_ready = 1'b0; acc = 0;
      for (int c = 0; c < 20 && acc < nfill; c++) begin
        @(negedge clk);
        took = in_valid && in_ready;
        if (took) acc++;
        step();
        if (took) in_data = in_data + 8'd1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      q.delete();
      #1;
      check(g, "async_rst_out_valid", int'(out_valid), 0);
      check(g, "async_rst_out_data", int'(out_data), 0);
      check(g, "async_rst_in_ready", int'(in_ready), 1);
      step();
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check(g, "rst_release_in_ready", int'(in_ready), 1);
      check(g, "rst_release_out_valid", int'(out_valid), 0);
      repeat (S + 4) @(negedge clk);
      step();

      // Random traffic: 50% valid, 30% ready, 1000 beats.
      acc = 0;
      for (int c = 0; c < 20000 && acc < 1000; c++) begin
        in_valid  = 1'($urandom_range(1, 0));
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(9, 0) < 3);
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        step();
      end
      check(g, "rand_beats", acc, 1000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4 * S + 10 && q.size() != 0; c++) begin
        @(negedge clk);
        step();
      end
      @(negedge clk);
      check(g, "rand_drained", q.size(), 0);
      check(g, "rand_final_out_valid", int'(out_valid), 0);
      mark_done();
    end
  end

  initial begin
    for (int t = 0; t < 60000 && n_done < NC; t++) @(posedge clk);
    if (n_done < NC) begin
      vectors++;
      errors++;
      $display("FAIL timeout: %0d of %0d configurations finished", n_done, NC);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
